// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types for the push-button debouncer. Holds the
//                debounce FSM state encoding and a helper that sizes the
//                stability tick counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Debounce FSM states. The level output is 1 in the upper half
    // (PRESSED, ARM_RELEASE) and 0 in the lower half.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } debounce_state_t;

    // Counter width able to hold 0 .. ticks. Never less than one bit.
    function automatic int count_width(input int ticks);
        int w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous level.
//                Both flops load RESET_VALUE on reset so the synchronized
//                output starts at the input's idle level.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic D_IN,
    output logic Q_OUT
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input; first stage may go metastable.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= D_IN;
            r_sync <= r_meta;
        end
    end

    assign Q_OUT = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Tick-driven debouncer for one mechanical push-button.
//                Synchronizes the raw pin, normalizes polarity so that
//                "pressed" is 1, and accepts a level change only after it has
//                held for STABLE_TICKS consecutive sample ticks. Produces a
//                clean level and one-cycle press/release strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic TICK_IN,
    input  logic BTN_IN,
    output logic BTN_LEVEL_OUT,
    output logic BTN_PRESS_OUT,
    output logic BTN_RELEASE_OUT
);

    localparam int c_cnt_w = count_width(STABLE_TICKS);
    // Count value at which the next qualifying tick completes acceptance.
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_TICKS - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic            w_pin_sync;
    logic            w_btn_s;

    debounce_state_t r_state;
    logic [c_cnt_w-1:0] r_count;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    // Synchronizer resets to the raw idle level so reset never looks like a press.
    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .CLK_IN (CLK_IN),
        .RST_IN (RST_IN),
        .D_IN   (BTN_IN),
        .Q_OUT  (w_pin_sync)
    );

    // Polarity-normalized button: 1 always means pressed.
    assign w_btn_s = w_pin_sync ^ ACTIVE_LOW;

    // Debounce FSM: arms on a level change, counts ticks while the new level
    // holds, and commits level and strobe on the same edge as the final tick.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_state   <= RELEASED;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    // Ticks are ignored here; counting starts after entry to ARM_PRESS.
                    if (w_btn_s) begin
                        r_state <= ARM_PRESS;
                        r_count <= '0;
                    end
                end
                ARM_PRESS: begin
                    // A bounce back to released outranks a coincident tick.
                    if (!w_btn_s) begin
                        r_state <= RELEASED;
                        r_count <= '0;
                    end else if (TICK_IN) begin
                        if (r_count == c_last) begin
                            r_state <= PRESSED;
                            r_count <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                end
                PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= ARM_RELEASE;
                        r_count <= '0;
                    end
                end
                ARM_RELEASE: begin
                    // A bounce back to pressed outranks a coincident tick.
                    if (w_btn_s) begin
                        r_state <= PRESSED;
                        r_count <= '0;
                    end else if (TICK_IN) begin
                        if (r_count == c_last) begin
                            r_state   <= RELEASED;
                            r_count   <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_count <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign BTN_LEVEL_OUT   = r_level;
    assign BTN_PRESS_OUT   = r_press;
    assign BTN_RELEASE_OUT = r_release;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Scoreboard bench for button_debounce. Stimulus pushes the
//                expected strobe (kind and edge number) into a per-DUT queue;
//                monitors pop and compare whenever a strobe appears.
//                Two instances: active-high (main) and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    typedef struct {
        bit is_press;
        int cyc;
    } ev_t;

    logic CLK_IN  = 1'b0;
    logic RST_IN  = 1'b1;
    logic TICK_IN = 1'b0;
    logic BTN_IN  = 1'b0;
    logic BTN_AL  = 1'b1;

    logic lvl0, prs0, rel0;
    logic lvl1, prs1, rel1;

    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail  = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    button_debounce #(.STABLE_TICKS(4), .ACTIVE_LOW(1'b0)) dut (
        .CLK_IN          (CLK_IN),
        .RST_IN          (RST_IN),
        .TICK_IN         (TICK_IN),
        .BTN_IN          (BTN_IN),
        .BTN_LEVEL_OUT   (lvl0),
        .BTN_PRESS_OUT   (prs0),
        .BTN_RELEASE_OUT (rel0)
    );

    button_debounce #(.STABLE_TICKS(4), .ACTIVE_LOW(1'b1)) dut_al (
        .CLK_IN          (CLK_IN),
        .RST_IN          (RST_IN),
        .TICK_IN         (TICK_IN),
        .BTN_IN          (BTN_AL),
        .BTN_LEVEL_OUT   (lvl1),
        .BTN_PRESS_OUT   (prs1),
        .BTN_RELEASE_OUT (rel1)
    );

    always #5 CLK_IN = ~CLK_IN;

    // cyc = number of rising edges seen so far
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Tick sampled on every rising edge whose number is a multiple of 10
    always @(negedge CLK_IN) TICK_IN = (((cyc + 1) % 10) == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Input changed after edge n: edge n+3 enters arming, ticks from edge
    // n+4 onward qualify; acceptance on the given qualifying tick.
    function automatic int accept_edge(input int n, input int ticks);
        int first;
        first = ((n + 4 + 9) / 10) * 10;
        return first + (ticks - 1) * 10;
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK_IN);
    endtask

    task automatic expect0(input bit is_press, input int n);
        ev_t e;
        e.is_press = is_press;
        e.cyc      = accept_edge(n, 4);
        q0.push_back(e);
    endtask

    task automatic expect1(input bit is_press, input int n);
        ev_t e;
        e.is_press = is_press;
        e.cyc      = accept_edge(n, 4);
        q1.push_back(e);
    endtask

    // Monitor for the active-high instance
    always @(negedge CLK_IN) begin : mon0
        ev_t e;
        if (prs0 === 1'b1 && rel0 === 1'b1) check("dut strobe overlap", 1, 0);
        if (prs0 === 1'b1 || rel0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut unexpected strobe: got press=%0b release=%0b at cyc %0d, expected none",
                         prs0, rel0, cyc);
            end else begin
                e = q0.pop_front();
                check("dut strobe kind(press)", 32'(prs0), 32'(e.is_press));
                check("dut strobe cycle", cyc, e.cyc);
                check("dut level with strobe", 32'(lvl0), 32'(e.is_press));
            end
        end
    end

    // Monitor for the active-low instance
    always @(negedge CLK_IN) begin : mon1
        ev_t e;
        if (prs1 === 1'b1 && rel1 === 1'b1) check("dut_al strobe overlap", 1, 0);
        if (prs1 === 1'b1 || rel1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut_al unexpected strobe: got press=%0b release=%0b at cyc %0d, expected none",
                         prs1, rel1, cyc);
            end else begin
                e = q1.pop_front();
                check("dut_al strobe kind(press)", 32'(prs1), 32'(e.is_press));
                check("dut_al strobe cycle", cyc, e.cyc);
                check("dut_al level with strobe", 32'(lvl1), 32'(e.is_press));
            end
        end
    end

    initial begin
        // Reset state
        wait_cyc(3);
        check("reset level", 32'(lvl0), 0);
        check("reset press", 32'(prs0), 0);
        check("reset release", 32'(rel0), 0);
        check("reset level al", 32'(lvl1), 0);
        RST_IN = 1'b0;

        // 1. Clean press
        wait_cyc(20);  BTN_IN = 1'b1; expect0(1'b1, 20);       // press at 60
        wait_cyc(90);  check("held level, no repeat", 32'(lvl0), 1);

        // 3. Release with a 2-tick glitch back to pressed
        wait_cyc(100); BTN_IN = 1'b0;
        wait_cyc(115); BTN_IN = 1'b1;
        wait_cyc(135); BTN_IN = 1'b0; expect0(1'b0, 135);      // release at 170
        wait_cyc(150); check("level during restarted arm", 32'(lvl0), 1);

        // 2. Bounce every 7 cycles, settling at 1 from cycle 256
        for (int i = 0; i <= 8; i++) begin
            wait_cyc(200 + 7 * i);
            BTN_IN = ((i % 2) == 0);
        end
        expect0(1'b1, 256);                                    // press at 290
        wait_cyc(300); check("level after bounce", 32'(lvl0), 1);

        // Back to released
        wait_cyc(320); BTN_IN = 1'b0; expect0(1'b0, 320);      // release at 360

        // 4. Reset after 3 ticks of ARM_PRESS (ticks at 410,420,430)
        wait_cyc(400); BTN_IN = 1'b1;
        wait_cyc(432); RST_IN = 1'b1;
        wait_cyc(433); RST_IN = 1'b0;
        check("mid-arm reset level", 32'(lvl0), 0);
        check("mid-arm reset press", 32'(prs0), 0);
        expect0(1'b1, 433);                                    // press at 470
        wait_cyc(490); check("level after fresh arm", 32'(lvl0), 1);

        // Reset from PRESSED with button held: level drops, re-accepts later
        wait_cyc(500); RST_IN = 1'b1;
        wait_cyc(501); RST_IN = 1'b0;
        check("reset from pressed level", 32'(lvl0), 0);
        check("reset from pressed release", 32'(rel0), 0);
        expect0(1'b1, 501);                                    // press at 540

        // 6. Abort edge reaches FSM on the edge of the 4th tick (650)
        wait_cyc(560); BTN_IN = 1'b0; expect0(1'b0, 560);      // release at 600
        wait_cyc(610); BTN_IN = 1'b1;
        wait_cyc(647); BTN_IN = 1'b0;
        wait_cyc(660); check("collision abort level", 32'(lvl0), 0);
        wait_cyc(680); BTN_IN = 1'b1; expect0(1'b1, 680);      // press at 720
        wait_cyc(740); check("press after collision", 32'(lvl0), 1);

        // 5. Active-low instance: idle 1, press by driving 0
        wait_cyc(745); check("al idle level", 32'(lvl1), 0);
        wait_cyc(750); BTN_AL = 1'b0; expect1(1'b1, 750);      // press at 790
        wait_cyc(800); check("al level pressed", 32'(lvl1), 1);

        // Every expected strobe must have been observed
        wait_cyc(830);
        check("dut pending strobes", q0.size(), 0);
        check("dut_al pending strobes", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_button_debounce
`default_nettype wire

// File: doc/button_debounce.md
# button_debounce

Tick-driven debouncer for one mechanical push-button input. Synchronizes the raw pin into the `CLK_IN` domain and accepts a level change only after it has held for `STABLE_TICKS` consecutive sample ticks. Outputs a clean level plus one-cycle press/release strobes. Sits directly downstream of the tick generator: its single-cycle `PULSE_OUT` drives `TICK_IN` here, and the strobes feed the lab's control/counter logic.

## Interface

- `STABLE_TICKS`, default 4: consecutive ticks the new level must persist before acceptance; legal range ≥1.
- `ACTIVE_LOW`, default 0: 1 means the pin reads 0 when pressed; it is inverted internally so "pressed" is always 1.

- `CLK_IN` input, 1 bit: sole clock, rising-edge.
- `RST_IN` input, 1 bit: reset, synchronous and active-high.
- `TICK_IN` input, 1 bit: sample enable, one `CLK_IN` cycle wide, from the tick generator.
- `BTN_IN` input, 1 bit: raw asynchronous button pin.
- `BTN_LEVEL_OUT` output, 1 bit: debounced pressed level.
- `BTN_PRESS_OUT` output, 1 bit: one-cycle strobe on accepted press.
- `BTN_RELEASE_OUT` output, 1 bit: one-cycle strobe on accepted release.

## Operation

- **Synchronizer:** 2 flops on `BTN_IN`, then XOR with `ACTIVE_LOW`, giving `btn_s` (1 = pressed).
- **Tick counter:** width `$clog2(STABLE_TICKS+1)`; counts only while arming.
- **RELEASED** (level 0):
  - `btn_s`=1 goes to ARM_PRESS with count 0.
- **ARM_PRESS** (level 0):
  - `btn_s`=0 returns to RELEASED and clears count. This bounce abort has priority over a same-cycle `TICK_IN`.
  - Otherwise, on `TICK_IN`: if count == `STABLE_TICKS`-1, go to PRESSED and assert `BTN_PRESS_OUT`; else increment count.
- **PRESSED** (level 1):
  - `btn_s`=0 goes to ARM_RELEASE with count 0.
- **ARM_RELEASE** (level 1): mirror of ARM_PRESS, with `btn_s`=1 as the abort condition. It ends in RELEASED and asserts `BTN_RELEASE_OUT`.
- **Level output:** `BTN_LEVEL_OUT` is 1 in PRESSED and ARM_RELEASE, 0 otherwise; it changes only on acceptance.
- **Strobes:** both are registered, high for exactly one cycle, and never high together. At most one strobe per acceptance; holding the button produces no repeats.
- **Ticks outside arming:** `TICK_IN` in RELEASED or PRESSED has no effect.
- **`STABLE_TICKS`=1:** the first tick while arming is accepted.

## Timing

- **Reset:** `RST_IN` sampled high forces, on that edge:
  - state RELEASED, count 0;
  - all three outputs 0;
  - synchronizer flops to the raw inactive value (`ACTIVE_LOW`), so no spurious press follows reset.
  
  Reset in the middle of arming discards progress. `RST_IN` overrides `TICK_IN` and `BTN_IN`.
- **Input latency:** `btn_s` reflects `BTN_IN` 2 cycles after it changes. Arming starts in the following cycle.
- **Acceptance timing:** acceptance happens on the edge sampling the `STABLE_TICKS`-th qualifying tick. Level and strobe update on that same edge.
- **Tick qualification:** a tick in the same cycle the state enters ARM_* does not count; counting begins the cycle after entry.
- **Worst-case latency:** accepted press ≤ 3 + `STABLE_TICKS`×tick_period cycles after a clean edge.
- **Tick spacing:** `TICK_IN` high on consecutive cycles is tolerated; each high cycle counts.

## Structure

- Shared package `debounce_pkg`: 2-bit state encoding constants RELEASED=0, ARM_PRESS=1, PRESSED=2, ARM_RELEASE=3.
- Sub-module `sync_2ff`: a 2-flop synchronizer with a reset-value parameter, reusable for other lab inputs.
- Remaining logic: one FSM with registered outputs in `button_debounce`.

## Test plan

All scenarios use `STABLE_TICKS`=4 and `TICK_IN` every 10 cycles.

1. **Clean press:** `BTN_IN` 0→1 held.
   - `BTN_PRESS_OUT` pulses exactly once, on the 4th tick after `btn_s` rises.
   - `BTN_LEVEL_OUT` goes 1 on that same edge.
2. **Bounce:** `BTN_IN` toggles every 7 cycles for 60 cycles, then settles at 1.
   - No strobe during bouncing.
   - One press strobe on the 4th tick after settling.
3. **Release:** from PRESSED, `BTN_IN`→0 held.
   - `BTN_RELEASE_OUT` pulses once after 4 ticks; `BTN_LEVEL_OUT`→0.
   - A 2-tick glitch back to 1 during arming restarts the count.
4. **Reset mid-arm:** assert `RST_IN` for 1 cycle after 3 ticks of ARM_PRESS.
   - All outputs 0; no press until 4 fresh ticks after release of reset with the button still held.
5. **`ACTIVE_LOW`=1:** `BTN_IN` idles 1.
   - No strobe out of reset.
   - `BTN_IN`→0 held gives a press strobe after 4 ticks.
6. **Abort/tick collision:** bounce edge reaches `btn_s` in the same cycle as the 4th tick.
   - The abort wins: no strobe, state RELEASED.
